// File: rtl/cavlc_pkg.sv
// Shared definitions for the CAVLC residual-block sequencer:
// one-hot state encoding, error codes and a width helper.
package cavlc_pkg;

  localparam int S_IDLE   = 0;
  localparam int S_TOTAL  = 1;
  localparam int S_T1S    = 2;
  localparam int S_PREFIX = 3;
  localparam int S_SUFFIX = 4;
  localparam int S_CALC   = 5;
  localparam int S_TZ     = 6;
  localparam int S_RUN    = 7;
  localparam int S_DONE   = 8;
  localparam int S_ERROR  = 9;
  localparam int N_ST     = 10;

  localparam logic [N_ST-1:0] ST_IDLE   = N_ST'(1 << S_IDLE);
  localparam logic [N_ST-1:0] ST_TOTAL  = N_ST'(1 << S_TOTAL);
  localparam logic [N_ST-1:0] ST_T1S    = N_ST'(1 << S_T1S);
  localparam logic [N_ST-1:0] ST_PREFIX = N_ST'(1 << S_PREFIX);
  localparam logic [N_ST-1:0] ST_SUFFIX = N_ST'(1 << S_SUFFIX);
  localparam logic [N_ST-1:0] ST_CALC   = N_ST'(1 << S_CALC);
  localparam logic [N_ST-1:0] ST_TZ     = N_ST'(1 << S_TZ);
  localparam logic [N_ST-1:0] ST_RUN    = N_ST'(1 << S_RUN);
  localparam logic [N_ST-1:0] ST_DONE   = N_ST'(1 << S_DONE);
  localparam logic [N_ST-1:0] ST_ERROR  = N_ST'(1 << S_ERROR);

  typedef enum logic [N_ST-1:0] {
    IDLE         = ST_IDLE,
    TOTAL_COEFFS = ST_TOTAL,
    T1S_FLAGS    = ST_T1S,
    LEVEL_PREFIX = ST_PREFIX,
    LEVEL_SUFFIX = ST_SUFFIX,
    CALC_LEVEL   = ST_CALC,
    TOTAL_ZEROS  = ST_TZ,
    RUN_BEFORES  = ST_RUN,
    BLK_DONE     = ST_DONE,
    ERROR        = ST_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_TC   = 2'd1;
  localparam logic [1:0] ERR_T1   = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++)
      if ((1 << k) < v) r = k + 1;
    return r;
  endfunction

endpackage

// File: rtl/cavlc_blk_counter.sv
// Block-in-batch counter: captures the batch size on start
// and flags the last block of the batch.
module cavlc_blk_counter
  import cavlc_pkg::*;
#(
  parameter int B_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           load,
  input  logic           adv,
  input  logic [B_W-1:0] num_blks,
  output logic [B_W-1:0] blk_idx,
  output logic           last
);

  logic [B_W-1:0] n_q;
  logic [B_W:0]   nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_idx <= '0;
      n_q     <= B_W'(1);
    end else if (ena) begin
      if (load) begin
        blk_idx <= '0;
        // an empty batch still decodes one block
        n_q     <= (num_blks == '0) ? B_W'(1) : num_blks;
      end else if (adv) begin
        blk_idx <= blk_idx + 1'b1;
      end
    end
  end

  assign nxt  = {1'b0, blk_idx} + 1'b1;
  assign last = nxt >= {1'b0, n_q};

endmodule

// File: rtl/cavlc_seq_fsm.sv
// CAVLC residual-block sequencer: walks coeff_token, levels,
// total_zeros and run_before for a batch of residual blocks.
module cavlc_seq_fsm
  import cavlc_pkg::*;
#(
  parameter  int MAX_COEFF = 16,
  parameter  int NUM_BLK   = 16,
  localparam int I_W = clog2(MAX_COEFF),
  localparam int B_W = clog2(NUM_BLK + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            start,
  input  logic [B_W-1:0]  num_blks,
  input  logic [4:0]      max_coeff_num,
  input  logic [4:0]      TotalCoeff,
  input  logic [4:0]      TotalCoeff_comb,
  input  logic [1:0]      TrailingOnes,
  input  logic [1:0]      TrailingOnes_comb,
  input  logic [3:0]      ZeroLeft,
  output logic [N_ST-1:0] state,
  output logic [I_W-1:0]  i,
  output logic [B_W-1:0]  blk_idx,
  output logic            idle,
  output logic            valid,
  output logic            batch_done,
  output logic            err,
  output logic [1:0]      err_code
);

  state_e         st_q, st_d;
  logic [I_W-1:0] i_d;
  logic           err_d;
  logic [1:0]     code_d;
  logic           load, adv, last;
  logic [4:0]     t1_r, t1_c;

  assign t1_r = {3'b000, TrailingOnes};
  assign t1_c = {3'b000, TrailingOnes_comb};

  always_comb begin
    st_d   = st_q;
    i_d    = i;
    err_d  = err;
    code_d = err_code;
    load   = 1'b0;
    adv    = 1'b0;
    unique case (1'b1)
      st_q[S_IDLE]: begin
        if (start) begin
          st_d   = TOTAL_COEFFS;
          load   = 1'b1;
          err_d  = 1'b0;
          code_d = ERR_NONE;
        end
      end
      st_q[S_TOTAL]: begin
        if (TotalCoeff_comb > max_coeff_num) begin
          st_d   = ERROR;
          err_d  = 1'b1;
          code_d = ERR_TC;
        end else if (t1_c > TotalCoeff_comb) begin
          st_d   = ERROR;
          err_d  = 1'b1;
          code_d = ERR_T1;
        end else begin
          i_d = I_W'(TotalCoeff_comb - 5'd1);
          if (TotalCoeff_comb == 5'd0)
            st_d = BLK_DONE;
          else if (TrailingOnes_comb != 2'd0)
            st_d = T1S_FLAGS;
          else
            st_d = LEVEL_PREFIX;
        end
      end
      st_q[S_T1S]: begin
        if (t1_r != TotalCoeff) begin
          st_d = LEVEL_PREFIX;
          i_d  = i - I_W'(TrailingOnes);
        end else if (TotalCoeff < max_coeff_num) begin
          st_d = TOTAL_ZEROS;
        end else begin
          st_d = BLK_DONE;
        end
      end
      st_q[S_PREFIX]: st_d = LEVEL_SUFFIX;
      st_q[S_SUFFIX]: st_d = CALC_LEVEL;
      st_q[S_CALC]: begin
        if (i != '0) begin
          st_d = LEVEL_PREFIX;
          i_d  = i - 1'b1;
        end else if (TotalCoeff < max_coeff_num) begin
          st_d = TOTAL_ZEROS;
        end else begin
          // full block: no total_zeros symbol in the stream
          st_d = RUN_BEFORES;
          i_d  = I_W'(TotalCoeff - 5'd1);
        end
      end
      st_q[S_TZ]: begin
        st_d = RUN_BEFORES;
        i_d  = I_W'(TotalCoeff - 5'd1);
      end
      st_q[S_RUN]: begin
        if (i == '0 || ZeroLeft == 4'd0)
          st_d = BLK_DONE;
        else
          i_d = i - 1'b1;
      end
      st_q[S_DONE]: begin
        if (last) begin
          st_d = IDLE;
        end else begin
          st_d = TOTAL_COEFFS;
          adv  = 1'b1;
        end
      end
      st_q[S_ERROR]: st_d = IDLE;
      default:       st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      i        <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (ena) begin
      st_q     <= st_d;
      i        <= i_d;
      err      <= err_d;
      err_code <= code_d;
    end
  end

  cavlc_blk_counter #(
    .B_W(B_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .load    (load),
    .adv     (adv),
    .num_blks(num_blks),
    .blk_idx (blk_idx),
    .last    (last)
  );

  assign state      = st_q;
  assign idle       = st_q[S_IDLE];
  assign valid      = ena & ~rst & st_q[S_DONE];
  assign batch_done = valid & last;

endmodule
